// File: rtl/tug_pkg.sv
// tug_pkg: shared FSM states, winner encodings and score limit for the tug-of-war controller
package tug_pkg;
    typedef enum logic [1:0] {PLAY, WIN_HOLD, FIELD_RST, GAME_OVER} state_t;
    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b10;
    localparam logic [1:0] WIN_RIGHT = 2'b01;
    localparam logic [2:0] SCORE_MAX = 3'd7;
    function automatic logic [2:0] sat_inc(input logic [2:0] s);
        return (s == SCORE_MAX) ? s : s + 3'd1;
    endfunction
endpackage

// File: rtl/key_pulse.sv
// key_pulse: 2-flop synchronizer plus rising-edge detector giving one press per key press
module key_pulse (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic press
);
    logic s1, s2, s3;
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= key;
            s2 <= s1;
            s3 <= s2;
        end
    end
    assign press = s2 & ~s3;
endmodule

// File: rtl/tug_game_ctrl.sv
// tug_game_ctrl: forwards player pushes to the playfield, detects wins, keeps score and re-arms rounds
module tug_game_ctrl
    import tug_pkg::*;
#(
    parameter int HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_l,
    input  logic       key_r,
    input  logic [9:1] led,
    output logic       pf_L,
    output logic       pf_R,
    output logic       pf_reset,
    output logic [2:0] score_l,
    output logic [2:0] score_r,
    output logic [1:0] winner,
    output logic       game_over
);
    state_t     state;
    logic [7:0] cnt;
    logic       press_l, press_r, lone_l, lone_r, maxed;
    logic       unused_led;

    key_pulse u_key_l (.clk(clk), .reset(reset), .key(key_l), .press(press_l));
    key_pulse u_key_r (.clk(clk), .reset(reset), .key(key_r), .press(press_r));

    assign lone_l     = press_l & ~press_r;
    assign lone_r     = press_r & ~press_l;
    assign maxed      = (score_l == SCORE_MAX) | (score_r == SCORE_MAX);
    assign unused_led = ^led[8:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PLAY;
            cnt       <= 8'd0;
            pf_L      <= 1'b0;
            pf_R      <= 1'b0;
            pf_reset  <= 1'b0;
            score_l   <= 3'd0;
            score_r   <= 3'd0;
            winner    <= WIN_NONE;
            game_over <= 1'b0;
        end else begin
            pf_L     <= 1'b0;
            pf_R     <= 1'b0;
            pf_reset <= 1'b0;
            case (state)
                PLAY: begin
                    if (lone_l && led[9]) begin
                        score_l <= sat_inc(score_l);
                        winner  <= WIN_LEFT;
                        cnt     <= 8'(HOLD_CYCLES);
                        state   <= WIN_HOLD;
                    end else if (lone_r && led[1]) begin
                        score_r <= sat_inc(score_r);
                        winner  <= WIN_RIGHT;
                        cnt     <= 8'(HOLD_CYCLES);
                        state   <= WIN_HOLD;
                    end else begin
                        pf_L <= lone_l;
                        pf_R <= lone_r;
                    end
                end
                WIN_HOLD: begin
                    cnt <= (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
                    if (cnt <= 8'd1) begin
                        state    <= FIELD_RST;
                        pf_reset <= 1'b1;
                        winner   <= WIN_NONE;
                    end
                end
                FIELD_RST: begin
                    state     <= maxed ? GAME_OVER : PLAY;
                    game_over <= maxed;
                end
                GAME_OVER: game_over <= 1'b1;
                default:   state <= PLAY;
            endcase
        end
    end
endmodule

// File: tb/tb_tug_game_ctrl.sv
// tb_tug_game_ctrl: scoreboard bench; stimulus queues expected playfield pulses, monitor pops and compares
module tb_tug_game_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_l = 1'b0;
    logic       key_r = 1'b0;
    logic [9:1] led = '0;
    logic       pf_L, pf_R, pf_reset, game_over;
    logic [2:0] score_l, score_r;
    logic [1:0] winner;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    typedef struct {
        logic [2:0] kind;
        int         cyc;
        logic [2:0] sl;
        logic [2:0] sr;
        logic [1:0] win;
        logic       go;
    } ev_t;
    ev_t q[$];

    localparam logic [2:0] EV_L = 3'b100, EV_R = 3'b010, EV_RST = 3'b001;

    tug_game_ctrl #(.HOLD_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .key_l(key_l), .key_r(key_r), .led(led),
        .pf_L(pf_L), .pf_R(pf_R), .pf_reset(pf_reset),
        .score_l(score_l), .score_r(score_r), .winner(winner), .game_over(game_over)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input logic [2:0] k, input int d, input logic [2:0] sl,
                             input logic [2:0] sr, input logic [1:0] w, input logic go);
        ev_t e;
        e.kind = k; e.cyc = cyc + d; e.sl = sl; e.sr = sr; e.win = w; e.go = go;
        q.push_back(e);
    endtask

    // Monitor: every playfield pulse must match the next queued expectation
    always @(negedge clk) begin
        if (pf_L | pf_R | pf_reset) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got {L,R,rst}=%b expected none (cycle %0d)",
                         {pf_L, pf_R, pf_reset}, cyc);
            end else begin
                ev_t e;
                e = q.pop_front();
                check("ev_kind", 32'({pf_L, pf_R, pf_reset}), 32'(e.kind));
                check("ev_cycle", cyc, e.cyc);
                check("ev_state", 32'({score_l, score_r, winner, game_over}),
                      32'({e.sl, e.sr, e.win, e.go}));
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        // Reset with key_l already held: one press after release
        key_l = 1'b1;
        tick(3);
        check("reset_outputs", 32'({pf_L, pf_R, pf_reset, score_l, score_r, winner, game_over}), 32'd0);
        reset = 1'b0;
        expect_ev(EV_L, 3, 3'd0, 3'd0, 2'b00, 1'b0);
        tick(6);
        key_l = 1'b0;
        tick(4);
        // Key held five cycles gives exactly one pf_L
        key_l = 1'b1;
        expect_ev(EV_L, 3, 3'd0, 3'd0, 2'b00, 1'b0);
        tick(5);
        key_l = 1'b0;
        tick(4);
        // Simultaneous presses are ignored
        key_l = 1'b1;
        key_r = 1'b1;
        tick(3);
        key_l = 1'b0;
        key_r = 1'b0;
        tick(4);
        check("simul_scores", 32'({score_l, score_r}), 32'd0);
        // Lone right press without edge LED
        key_r = 1'b1;
        expect_ev(EV_R, 3, 3'd0, 3'd0, 2'b00, 1'b0);
        tick(2);
        key_r = 1'b0;
        tick(4);
        // Left win at led[9]
        led = 9'b1_0000_0000;
        key_l = 1'b1;
        expect_ev(EV_RST, 11, 3'd1, 3'd0, 2'b00, 1'b0);
        tick(3);
        check("win_l_winner_first", 32'(winner), 32'(2'b10));
        check("win_l_score", 32'({score_l, score_r}), 32'({3'd1, 3'd0}));
        key_l = 1'b0;
        led = '0;
        tick(7);
        check("win_l_winner_last", 32'(winner), 32'(2'b10));
        tick(3);
        check("back_in_play_winner", 32'(winner), 32'(2'b00));
        key_l = 1'b1;
        expect_ev(EV_L, 3, 3'd1, 3'd0, 2'b00, 1'b0);
        tick(3);
        key_l = 1'b0;
        tick(3);
        // Right win with key_r held into the next round
        led = 9'b0_0000_0001;
        key_r = 1'b1;
        expect_ev(EV_RST, 11, 3'd1, 3'd1, 2'b00, 1'b0);
        tick(5);
        led = '0;
        tick(15);
        key_r = 1'b0;
        tick(2);
        key_r = 1'b1;
        expect_ev(EV_R, 3, 3'd1, 3'd1, 2'b00, 1'b0);
        tick(3);
        key_r = 1'b0;
        tick(3);
        // Reset three cycles into WIN_HOLD
        led = 9'b1_0000_0000;
        key_l = 1'b1;
        tick(3);
        key_l = 1'b0;
        led = '0;
        check("hold_pre_reset_winner", 32'(winner), 32'(2'b10));
        tick(2);
        reset = 1'b1;
        tick(1);
        check("midhold_reset_outputs", 32'({pf_L, pf_R, pf_reset, score_l, score_r, winner, game_over}), 32'd0);
        reset = 1'b0;
        tick(15);
        // Seven right wins end the game
        led = 9'b0_0000_0001;
        for (int i = 1; i <= 7; i++) begin
            key_r = 1'b1;
            expect_ev(EV_RST, 11, 3'd0, 3'(i), 2'b00, 1'b0);
            tick(2);
            key_r = 1'b0;
            tick(11);
        end
        check("gameover_flag", 32'(game_over), 32'd1);
        check("gameover_scores", 32'({score_l, score_r}), 32'({3'd0, 3'd7}));
        key_r = 1'b1;
        tick(3);
        key_r = 1'b0;
        led = 9'b1_0000_0000;
        key_l = 1'b1;
        tick(3);
        key_l = 1'b0;
        tick(6);
        check("frozen_scores", 32'({score_l, score_r, winner}), 32'({3'd0, 3'd7, 2'b00}));
        check("gameover_sticky", 32'(game_over), 32'd1);
        check("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
